// File: rtl/rack_jtag_pkg.sv
// Shared definitions for the rack JTAG master: opcodes, FSM states,
// fixed TAP-reset pattern and chain-select length.
package rack_jtag_pkg;

  localparam logic [1:0] OP_SHIFT  = 2'd0;
  localparam logic [1:0] OP_SELECT = 2'd1;
  localparam logic [1:0] OP_TAPRST = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    GUARD,
    RSP
  } state_t;

  // Bit 0 goes out first: five ones reach Test-Logic-Reset, the final zero
  // parks the TAP in Run-Test/Idle.
  localparam logic [5:0] TAPRST_TMS = 6'b011111;
  localparam int         TAPRST_LEN = 6;
  localparam int         SELECT_LEN = 8;

  // Reverse a byte so an LSB-first shifter can emit it MSB first.
  function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rack_jtag_tck_gen.sv
// TTCK phase timer: counts CLKDIV system clocks per TTCK half-period and
// strobes phase_done on the last cycle of each phase. Held at zero while
// restart is high so every command starts with a full-length first phase.
module rack_jtag_tck_gen #(
  parameter int CLKDIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic phase_done
);

  logic [7:0] cnt_reg;

  assign phase_done = (cnt_reg == 8'(CLKDIV - 1));

  // Free-running phase counter, wrapping at CLKDIV.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else if (restart || phase_done) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/rack_jtag_master.sv
// Command-driven JTAG engine driving the rack JTAG mux (TTCK/TTMS/TTDI/
// TCTRL_B) and capturing TTDO. Commands: SHIFT, SELECT (load mux chain
// register with TCTRL_B low), TAPRST.
// Optional build macro: RACK_JTAG_TDO_SYNC_EN adds a 2-flop TTDO
// synchronizer and moves capture to the last cycle of each HIGH phase.
module rack_jtag_master
  import rack_jtag_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_tdo,
  output logic        TTCK,
  output logic        TTMS,
  output logic        TTDI,
  output logic        TCTRL_B,
  input  logic        TTDO
);

  if (CLKDIV < 1 || CLKDIV > 255) begin : g_bad_clkdiv
    $error("rack_jtag_master: CLKDIV must be in 1..255");
  end

  state_t      state_reg;
  logic        shift_reg;     // current command captures TDO
  logic        sel_reg;       // current command is a chain select
  logic [4:0]  last_bit_reg;  // index of the final bit
  logic [4:0]  bit_cnt_reg;
  // Bits still to be sent after the one currently on TTMS/TTDI.
  logic [30:0] tms_sr_reg;
  logic [30:0] tdi_sr_reg;
  logic [7:0]  sel_rev;
  logic        phase_done;
  logic        tck_restart;
  logic        tdo_capture;

  assign cmd_ready   = (state_reg == IDLE);
  assign tck_restart = (state_reg == IDLE) || (state_reg == RSP);
  assign sel_rev     = bit_reverse8(cmd_tdi[7:0]);

  rack_jtag_tck_gen #(
    .CLKDIV(CLKDIV)
  ) u_tck_gen (
    .CLK       (CLK),
    .RST       (RST),
    .restart   (tck_restart),
    .phase_done(phase_done)
  );

`ifdef RACK_JTAG_TDO_SYNC_EN
  if (CLKDIV < 3) begin : g_sync_clkdiv_check
    $error("rack_jtag_master: CLKDIV must be >= 3 with the TDO synchronizer");
  end

  logic [1:0] tdo_sync_reg;

  // Two-flop synchronizer for the asynchronous TTDO return path.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tdo_sync_reg <= 2'b00;
    end else begin
      tdo_sync_reg <= {tdo_sync_reg[0], TTDO};
    end
  end

  assign tdo_capture = tdo_sync_reg[1];
`else
  assign tdo_capture = TTDO;
`endif

  // Command FSM: bit sequencing, pin drive, TDO capture and response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      shift_reg    <= 1'b0;
      sel_reg      <= 1'b0;
      last_bit_reg <= '0;
      bit_cnt_reg  <= '0;
      tms_sr_reg   <= '0;
      tdi_sr_reg   <= '0;
      rsp_valid    <= 1'b0;
      rsp_tdo      <= '0;
      TTCK         <= 1'b0;
      TTMS         <= 1'b1;
      TTDI         <= 1'b0;
      TCTRL_B      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            state_reg   <= LOW;
            rsp_tdo     <= '0;
            bit_cnt_reg <= '0;
            case (cmd_op)
              OP_SHIFT: begin
                shift_reg    <= 1'b1;
                sel_reg      <= 1'b0;
                last_bit_reg <= cmd_len;
                tms_sr_reg   <= cmd_tms[31:1];
                tdi_sr_reg   <= cmd_tdi[31:1];
                TTMS         <= cmd_tms[0];
                TTDI         <= cmd_tdi[0];
              end
              OP_SELECT: begin
                // TTMS is deliberately left untouched so the TAPs behind
                // the mux see no TMS change.
                shift_reg    <= 1'b0;
                sel_reg      <= 1'b1;
                last_bit_reg <= 5'(SELECT_LEN - 1);
                tms_sr_reg   <= '0;
                tdi_sr_reg   <= {24'b0, sel_rev[7:1]};
                TTDI         <= sel_rev[0];
                TCTRL_B      <= 1'b0;
              end
              default: begin
                // TAPRST and the reserved opcode.
                shift_reg    <= 1'b0;
                sel_reg      <= 1'b0;
                last_bit_reg <= 5'(TAPRST_LEN - 1);
                tms_sr_reg   <= {26'b0, TAPRST_TMS[5:1]};
                tdi_sr_reg   <= '0;
                TTMS         <= TAPRST_TMS[0];
                TTDI         <= 1'b0;
              end
            endcase
          end
        end

        LOW: begin
          if (phase_done) begin
            TTCK      <= 1'b1;
            state_reg <= HIGH;
`ifndef RACK_JTAG_TDO_SYNC_EN
            if (shift_reg) begin
              rsp_tdo[bit_cnt_reg] <= tdo_capture;
            end
`endif
          end
        end

        HIGH: begin
          if (phase_done) begin
`ifdef RACK_JTAG_TDO_SYNC_EN
            if (shift_reg) begin
              rsp_tdo[bit_cnt_reg] <= tdo_capture;
            end
`endif
            TTCK <= 1'b0;
            if (bit_cnt_reg == last_bit_reg) begin
              if (sel_reg) begin
                state_reg <= GUARD;
              end else begin
                state_reg <= RSP;
                rsp_valid <= 1'b1;
              end
            end else begin
              state_reg   <= LOW;
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              tms_sr_reg  <= {1'b0, tms_sr_reg[30:1]};
              tdi_sr_reg  <= {1'b0, tdi_sr_reg[30:1]};
              TTDI        <= tdi_sr_reg[0];
              if (!sel_reg) begin
                TTMS <= tms_sr_reg[0];
              end
            end
          end
        end

        GUARD: begin
          // Keep TCTRL_B low one extra half-period past the last falling edge.
          if (phase_done) begin
            TCTRL_B   <= 1'b1;
            rsp_valid <= 1'b1;
            state_reg <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rack_jtag_master.sv
// Directed self-checking bench for rack_jtag_master (CLKDIV = 2), with a
// behavioural rack mux model (chain register + gated target TCK) and a
// pattern-driven TDO source.
module tb_rack_jtag_master;

  localparam int CLKDIV = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_tms = '0;
  logic [31:0] cmd_tdi = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_tdo;
  logic        TTCK, TTMS, TTDI, TCTRL_B;
  logic        TTDO;

  always #5 CLK = ~CLK;

  rack_jtag_master #(.CLKDIV(CLKDIV)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .cmd_tms  (cmd_tms),
    .cmd_tdi  (cmd_tdi),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_tdo  (rsp_tdo),
    .TTCK     (TTCK),
    .TTMS     (TTMS),
    .TTDI     (TTDI),
    .TCTRL_B  (TCTRL_B),
    .TTDO     (TTDO)
  );

  int total = 0;
  int bad   = 0;

  // Mux / target model
  logic [7:0]  mux_reg = 8'h00;
  logic [7:0]  rise_cnt = 8'd0;
  logic [7:0]  base = 8'd0;
  logic [31:0] tdo_pat = '0;
  logic        tms_cap [0:255];
  logic        tdi_cap [0:255];
  int          tgt_rises = 0;
  logic [4:0]  tdo_idx;
  logic        tgt_tck;

  assign tdo_idx = 5'(rise_cnt - base);
  assign TTDO    = tdo_pat[tdo_idx];
  assign tgt_tck = TTCK & TCTRL_B;

  always @(posedge TTCK) begin
    tms_cap[rise_cnt] <= TTMS;
    tdi_cap[rise_cnt] <= TTDI;
    rise_cnt <= rise_cnt + 8'd1;
    if (!TCTRL_B) mux_reg <= {mux_reg[6:0], TTDI};
  end

  always @(posedge tgt_tck) tgt_rises <= tgt_rises + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_tms(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = tms_cap[8'(base + 8'(i))];
    return v;
  endfunction

  function automatic logic [31:0] get_tdi(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = tdi_cap[8'(base + 8'(i))];
    return v;
  endfunction

  // Offer one command; returns #1 after the accept edge (cycle 1).
  task automatic issue(input string tag, input logic [1:0] op, input logic [4:0] len,
                       input logic [31:0] tms, input logic [31:0] tdi);
    @(negedge CLK);
    base      = rise_cnt;
    cmd_op    = op;
    cmd_len   = len;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    cmd_valid = 1'b1;
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    // Fields are only sampled at accept; scramble them afterwards.
    cmd_op  = ~op;
    cmd_len = ~len;
    cmd_tms = ~tms;
    cmd_tdi = ~tdi;
    $display("cmd %s op=%0d len=%0d tms=%h tdi=%h", tag, op, len, tms, tdi);
  endtask

  // Watch until rsp_valid, collecting latency and TTCK/TCTRL_B statistics.
  task automatic wait_rsp(output int lat, output int lowcnt, output int pulses, output int badrun);
    int run = 0;
    lat = -1; lowcnt = 0; pulses = 0; badrun = 0;
    for (int c = 1; c <= 2000; c++) begin
      if (TCTRL_B === 1'b0) lowcnt++;
      if (TTCK === 1'b1) run++;
      else if (run != 0) begin
        pulses++;
        if (run != CLKDIV) badrun++;
        run = 0;
      end
      if (rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge CLK);
      #1;
    end
    $display("rsp lat=%0d tdo=%h pulses=%0d", lat, rsp_tdo, pulses);
  endtask

  task automatic ack_rsp(input string tag);
    @(negedge CLK);
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int lat, lowcnt, pulses, badrun, tgt0;
    bit found;

    // Reset and idle
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check("rst_ttck",    32'(TTCK), 32'd0);
    check("rst_ttms",    32'(TTMS), 32'd1);
    check("rst_ttdi",    32'(TTDI), 32'd0);
    check("rst_tctrl",   32'(TCTRL_B), 32'd1);
    check("rst_ready",   32'(cmd_ready), 32'd1);
    check("rst_rvalid",  32'(rsp_valid), 32'd0);
    check("rst_tdo",     rsp_tdo, 32'd0);
    $display("reset idle checked");

    // SHIFT 4 bits, TDO 1,1,0,1
    tdo_pat = 32'h0000000B;
    issue("shift4", 2'd0, 5'd3, 32'h8, 32'h5);
    wait_rsp(lat, lowcnt, pulses, badrun);
    check("shift4_lat",    32'(lat), 32'd17);
    check("shift4_tdo",    rsp_tdo, 32'h0000000B);
    check("shift4_pulses", 32'(pulses), 32'd4);
    check("shift4_hightime", 32'(badrun), 32'd0);
    check("shift4_tms",    get_tms(4), 32'h8);
    check("shift4_tdi",    get_tdi(4), 32'h5);
    check("shift4_tctrl",  32'(lowcnt), 32'd0);
    check("shift4_ttck_idle", 32'(TTCK), 32'd0);
    ack_rsp("shift4");
    check("shift4_ttms_hold", 32'(TTMS), 32'd1);

    // TAPRST (TDO held high: must not be captured)
    tdo_pat = 32'hFFFFFFFF;
    issue("taprst", 2'd2, 5'd0, 32'h0, 32'h0);
    wait_rsp(lat, lowcnt, pulses, badrun);
    check("taprst_lat",    32'(lat), 32'd25);
    check("taprst_pulses", 32'(pulses), 32'd6);
    check("taprst_tms",    get_tms(6), 32'h1F);
    check("taprst_tdi",    get_tdi(6), 32'h0);
    check("taprst_tdo",    rsp_tdo, 32'h0);
    ack_rsp("taprst");
    check("taprst_ttms_end", 32'(TTMS), 32'd0);

    // SELECT 8'hA5 through the mux model
    tgt0 = tgt_rises;
    issue("select", 2'd1, 5'd0, 32'hFFFFFFFF, 32'h000000A5);
    wait_rsp(lat, lowcnt, pulses, badrun);
    check("select_lat",     32'(lat), 32'd35);
    check("select_tctrl_low", 32'(lowcnt), 32'd34);
    check("select_mux",     32'(mux_reg), 32'hA5);
    check("select_tgt_tck", 32'(tgt_rises - tgt0), 32'd0);
    check("select_pulses",  32'(pulses), 32'd8);
    check("select_tms_hold", get_tms(8), 32'h0);
    check("select_tdo",     rsp_tdo, 32'h0);
    check("select_tctrl_end", 32'(TCTRL_B), 32'd1);
    ack_rsp("select");

    // SHIFT then back-pressure for 10 cycles
    tdo_pat = 32'h0000005A;
    issue("shift8", 2'd0, 5'd7, 32'h0, 32'hC3);
    wait_rsp(lat, lowcnt, pulses, badrun);
    check("shift8_lat", 32'(lat), 32'd33);
    check("shift8_tdi", get_tdi(8), 32'hC3);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      cmd_op    = 2'd0;
      cmd_valid = (k == 4);
      @(posedge CLK);
      #1;
      check("bp_rvalid", 32'(rsp_valid), 32'd1);
      check("bp_tdo",    rsp_tdo, 32'h0000005A);
      check("bp_ready",  32'(cmd_ready), 32'd0);
      check("bp_ttck",   32'(TTCK), 32'd0);
    end
    cmd_valid = 1'b0;
    ack_rsp("shift8");
    @(posedge CLK);
    #1;
    check("bp_no_accept", 32'(cmd_ready), 32'd1);

    // Reset during the 4th HIGH phase of a SELECT
    issue("select_abort", 2'd1, 5'd0, 32'h0, 32'h0000003C);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (8'(rise_cnt - base) == 8'd4 && TTCK === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    check("abort_reach_high4", 32'(found), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("abort_tctrl",  32'(TCTRL_B), 32'd1);
    check("abort_ttck",   32'(TTCK), 32'd0);
    check("abort_rvalid", 32'(rsp_valid), 32'd0);
    check("abort_ready",  32'(cmd_ready), 32'd1);
    $display("reset asserted mid-select");
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);

    // SHIFT after abort completes normally
    tdo_pat = 32'h00000016;
    issue("shift5", 2'd0, 5'd4, 32'h3, 32'h1A);
    wait_rsp(lat, lowcnt, pulses, badrun);
    check("shift5_lat",    32'(lat), 32'd21);
    check("shift5_tdo",    rsp_tdo, 32'h00000016);
    check("shift5_tms",    get_tms(5), 32'h3);
    check("shift5_tdi",    get_tdi(5), 32'h1A);
    check("shift5_hightime", 32'(badrun), 32'd0);
    ack_rsp("shift5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rack_jtag_master.md
# rack_jtag_master

Command-driven JTAG engine that sits directly upstream of the rack JTAG multiplexer and drives its TTCK/TTMS/TTDI/TCTRL_B inputs while capturing its TTDO output. A host-side controller issues shift, chain-select and TAP-reset commands over a valid/ready interface. For each shift command the block returns the captured TDO bits over a second valid/ready interface. Chain-select commands load the mux's 8-bit chain-enable register with TCTRL_B held low.

## Interface
Parameters:
- CLKDIV, 4: TTCK half-period in CLK cycles. Legal range is 1..255.

Ports:
- CLK  in  1  single system clock.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command. Equals (state == IDLE).
- cmd_op  in  2  command opcode: 0 = SHIFT, 1 = SELECT, 2 = TAPRST, 3 = reserved (treated as TAPRST).
- cmd_len  in  5  SHIFT length minus 1, giving 1..32 bits. Ignored for other opcodes.
- cmd_tms  in  32  per-bit TMS values for SHIFT, bit 0 first.
- cmd_tdi  in  32  per-bit TDI values for SHIFT, bit 0 first. For SELECT, bits [7:0] are the chain-enable value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_tdo  out  32  captured TDO. Bit i holds the value captured at rising edge i; unused bits are 0. For SELECT and TAPRST this field is 0.
- TTCK, TTMS, TTDI, TCTRL_B  out  1 each  to the mux.
- TTDO  in  1  from the mux.

## Operation
- States:
  - IDLE: accepts a command on cmd_valid && cmd_ready.
  - LOW: TTCK = 0 for CLKDIV cycles.
  - HIGH: TTCK = 1 for CLKDIV cycles.
  - GUARD: SELECT only; TCTRL_B held low for CLKDIV cycles after the last falling edge.
  - RSP: rsp_valid asserted until rsp_ready.
- Bit sequencing:
  - Entering LOW for bit i drives TTMS and TTDI for that bit.
  - The LOW→HIGH transition is the rising edge.
  - HIGH→LOW advances the bit counter.
  - After the final HIGH, the block goes to RSP (SHIFT, TAPRST) or GUARD (SELECT). GUARD is followed by RSP.
- SHIFT: N = cmd_len + 1 bits, using cmd_tms[i] and cmd_tdi[i]. TCTRL_B = 1.
- SELECT:
  - TCTRL_B = 0 from the first LOW cycle through the end of GUARD.
  - 8 bits are sent MSB first (cmd_tdi[7] first, cmd_tdi[0] last), so the mux register ends equal to cmd_tdi[7:0].
  - TTMS holds its prior value throughout.
- TAPRST: 6 bits with TMS = 1,1,1,1,1,0 and TDI = 0. This leaves the TAP in Run-Test/Idle.
- TTDO capture: TTDO is registered into rsp_tdo[i] on the CLK edge at which TTCK goes 0→1 for bit i.
- Idle levels: after any command, TTCK returns to 0. TTMS and TTDI hold their last driven values. TCTRL_B = 1.
- rsp_tdo clearing: rsp_tdo is cleared when a command is accepted.
- Back-pressure: no new command is accepted while rsp_valid is high. cmd_ready is 0 in every state except IDLE.

## Timing
- Reset values:
  - State: IDLE.
  - TTCK 0, TTMS 1, TTDI 0, TCTRL_B 1.
  - rsp_valid 0, rsp_tdo 0, cmd_ready 1.
- Reset is asynchronous: asserting RST mid-command forces all outputs to their reset values in the same instant. TCTRL_B releases high even mid-SELECT. No response is produced for the aborted command.
- Latency: handshake accepted at cycle 0; first LOW at cycle 1. rsp_valid rises at:
  - SHIFT: cycle 1 + 2·N·CLKDIV.
  - TAPRST: cycle 1 + 12·CLKDIV.
  - SELECT: cycle 1 + 17·CLKDIV.
- RSP handshake: RSP → IDLE occurs on the cycle where rsp_valid && rsp_ready. cmd_ready rises the following cycle, so there is no same-cycle command accept.
- Command fields are sampled only at the accept handshake and may change afterwards.

## Configuration
- RACK_JTAG_TDO_SYNC_EN defined:
  - TTDO passes through a 2-flop synchronizer.
  - Capture moves to the last CLK cycle of HIGH for bit i, using the synchronized value.
  - CLKDIV must be ≥ 3; an elaboration-time check errors otherwise.
- RACK_JTAG_TDO_SYNC_EN undefined: raw TTDO is captured at the rising edge as described in Operation. No synchronizer flops exist.

## Structure
- Shared package rack_jtag_pkg holds:
  - Opcode constants OP_SHIFT, OP_SELECT, OP_TAPRST.
  - The state enum (IDLE, LOW, HIGH, GUARD, RSP).
  - TAPRST pattern constants TAPRST_TMS = 6'b011111 and TAPRST_LEN = 6.
  - SELECT_LEN = 8.
- Sub-module rack_jtag_tck_gen: CLKDIV phase counter with a phase-done strobe, restartable from IDLE.
- The main module holds the FSM, the shift registers and the capture logic.

## Test plan
- Reset, then idle 20 cycles → TTCK 0, TTMS 1, TCTRL_B 1, cmd_ready 1, rsp_valid 0.
- SHIFT, CLKDIV = 2, cmd_len = 3, tms = 4'b1000, tdi = 4'b0101, with TTDO from a model that returns 1,1,0,1 → rsp_tdo = 32'h0000000B and rsp_valid at cycle 17. The four TTCK pulses each have high time 2.
- SELECT, cmd_tdi = 8'hA5, through the real mux model → mux register = 8'hA5 and TCTRL_B low for exactly 17·CLKDIV cycles. Target TCK never toggles.
- TAPRST → six TTCK pulses with TMS 1,1,1,1,1,0, then rsp_tdo = 0.
- Hold rsp_ready low for 10 cycles after a SHIFT → rsp_valid and rsp_tdo stable, cmd_ready 0. A cmd_valid pulse during this time is not accepted.
- Assert RST at the 4th HIGH phase of a SELECT → TCTRL_B = 1 and TTCK = 0 immediately, no rsp_valid. The next SHIFT then completes normally.
